// File: rtl/darkroom_pkg.sv
// Shared types and constants for the darkroom SPI scheduler.
package darkroom_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_HEADER  = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_DELAY   = 3'd4
   } state_e;

   localparam int unsigned HEADER_BYTES = 1;
   localparam int unsigned WORD_BYTES   = 4;
   localparam logic [7:0]  CRC8_POLY    = 8'h07;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/darkroom_crc8.sv
// Byte-serial CRC-8 (MSB-first, init 0x00) with synchronous clear and byte enable.
module darkroom_crc8
   import darkroom_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear_i,
   input  logic       en_i,
   input  logic [7:0] data_i,
   output logic [7:0] crc_o
);

   logic [7:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clear_i) begin
         crc_d = '0;
      end else if (en_i) begin
         crc_d = crc_q ^ data_i;
         for (int unsigned b = 0; b < 8; b++) begin
            crc_d = crc_d[7] ? ({crc_d[6:0], 1'b0} ^ CRC8_POLY) : {crc_d[6:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) crc_q <= '0;
      else          crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/darkroom_spi_scheduler.sv
// Captures sensor words, serves them over Avalon-MM and streams dirty frames as SPI bytes.
// Define DARKROOM_CRC8_EN to append a CRC-8 byte to every frame.
module darkroom_spi_scheduler
   import darkroom_pkg::*;
#(
   parameter int unsigned NUMBER_OF_SENSORS = 8,
   parameter int unsigned SENSORS_PER_FRAME = 8,
   parameter int unsigned INTER_FRAME_DELAY = 1024,
   parameter int unsigned ADDR_W            = 7
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [32*NUMBER_OF_SENSORS-1:0] sensor_data_i,
   input  logic [NUMBER_OF_SENSORS-1:0]    sensor_update_i,
   input  logic                            trigger_me,
   input  logic [ADDR_W-1:0]               avs_address,
   input  logic                            avs_read,
   output logic [31:0]                     avs_readdata,
   output logic                            avs_waitrequest,
   output logic [7:0]                      tx_data,
   output logic                            tx_valid,
   input  logic                            tx_ready,
   output logic                            tx_last
);

   localparam int unsigned N         = NUMBER_OF_SENSORS;
   localparam int unsigned SPF       = SENSORS_PER_FRAME;
   localparam int unsigned NF        = ceil_div(N, SPF);
   localparam int unsigned PAY_BYTES = WORD_BYTES * SPF;
`ifdef DARKROOM_CRC8_EN
   localparam int unsigned LAST_IDX  = PAY_BYTES;
`else
   localparam int unsigned LAST_IDX  = PAY_BYTES - 1;
`endif

   state_e              state_q, state_d;
   logic [32*N-1:0]     shadow_q;
   logic [N-1:0]        dirty_q, clr_mask, frame_mask;
   logic                send_all_q, send_all_d, frame_dirty, last_byte;
   logic [6:0]          frame_ctr_q, frame_ctr_d;
   logic [7:0]          byte_idx_q, byte_idx_d, byte_sel;
   logic [31:0]         dly_q, dly_d;
   logic [32*SPF-1:0]   txbuf_q, txbuf_d, frame_words;
   logic                rd_done_q;
   logic [31:0]         readdata_q, rd_word, addr32;
   logic [63:0]         dirty64;

`ifdef DARKROOM_CRC8_EN
   logic       crc_clear, crc_en;
   logic [7:0] crc_val;

   assign crc_clear = (state_q == ST_LOAD);
   assign crc_en    = tx_valid & tx_ready;

   darkroom_crc8 u_crc (
      .clock   (clock),
      .reset_n (reset_n),
      .clear_i (crc_clear),
      .en_i    (crc_en),
      .data_i  (tx_data),
      .crc_o   (crc_val)
   );
`endif

   // Words and dirty bits belonging to the frame selected by frame_ctr_q; slots past N stay zero.
   always_comb begin
      frame_dirty = 1'b0;
      frame_mask  = '0;
      frame_words = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (7'(i / SPF) == frame_ctr_q) begin
            frame_mask[i]                      = 1'b1;
            frame_dirty                        = frame_dirty | dirty_q[i];
            frame_words[(i % SPF)*32 +: 32]    = shadow_q[i*32 +: 32];
         end
      end
   end

   always_comb begin
      byte_sel = '0;
      for (int unsigned b = 0; b < PAY_BYTES; b++) begin
         if (byte_idx_q == 8'(b)) byte_sel = txbuf_q[b*8 +: 8];
      end
`ifdef DARKROOM_CRC8_EN
      if (byte_idx_q == 8'(PAY_BYTES)) byte_sel = crc_val;
`endif
   end

   always_comb begin
      state_d     = state_q;
      send_all_d  = send_all_q;
      frame_ctr_d = frame_ctr_q;
      byte_idx_d  = byte_idx_q;
      dly_d       = dly_q;
      txbuf_d     = txbuf_q;
      clr_mask    = '0;
      tx_valid    = 1'b0;
      tx_last     = 1'b0;
      tx_data     = '0;
      last_byte   = (byte_idx_q == 8'(LAST_IDX));
      case (state_q)
         ST_IDLE: begin
            if (trigger_me) begin
               send_all_d  = 1'b1;
               frame_ctr_d = '0;
               state_d     = ST_LOAD;
            end else if (|dirty_q) begin
               send_all_d  = 1'b0;
               frame_ctr_d = '0;
               state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (frame_ctr_q >= 7'(NF)) begin
               state_d = ST_IDLE;
            end else if (send_all_q || frame_dirty) begin
               txbuf_d    = frame_words;
               clr_mask   = frame_mask;
               byte_idx_d = '0;
               state_d    = ST_HEADER;
            end else begin
               frame_ctr_d = frame_ctr_q + 7'd1;
            end
         end
         ST_HEADER: begin
            tx_valid = 1'b1;
            tx_data  = {send_all_q, frame_ctr_q};
            if (tx_ready) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            tx_valid = 1'b1;
            tx_data  = byte_sel;
            tx_last  = last_byte;
            if (tx_ready) begin
               if (last_byte) begin
                  dly_d = '0;
                  if (INTER_FRAME_DELAY <= 1) begin
                     frame_ctr_d = frame_ctr_q + 7'd1;
                     state_d     = ST_LOAD;
                  end else begin
                     state_d = ST_DELAY;
                  end
               end else begin
                  byte_idx_d = byte_idx_q + 8'd1;
               end
            end
         end
         ST_DELAY: begin
            // LOAD is the last idle cycle, so DELAY itself lasts INTER_FRAME_DELAY-1 cycles.
            if (dly_q >= 32'(INTER_FRAME_DELAY - 2)) begin
               frame_ctr_d = frame_ctr_q + 7'd1;
               state_d     = ST_LOAD;
            end else begin
               dly_d = dly_q + 32'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         send_all_q  <= 1'b0;
         frame_ctr_q <= '0;
         byte_idx_q  <= '0;
         dly_q       <= '0;
         txbuf_q     <= '0;
         shadow_q    <= '0;
         dirty_q     <= '0;
      end else begin
         state_q     <= state_d;
         send_all_q  <= send_all_d;
         frame_ctr_q <= frame_ctr_d;
         byte_idx_q  <= byte_idx_d;
         dly_q       <= dly_d;
         txbuf_q     <= txbuf_d;
         dirty_q     <= (dirty_q & ~clr_mask) | sensor_update_i;
         for (int unsigned i = 0; i < N; i++) begin
            if (sensor_update_i[i]) shadow_q[i*32 +: 32] <= sensor_data_i[i*32 +: 32];
         end
      end
   end

   assign addr32  = 32'(avs_address);
   assign dirty64 = 64'(dirty_q);

   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (addr32 == i) rd_word = shadow_q[i*32 +: 32];
      end
      if (addr32 == N)     rd_word = dirty64[31:0];
      if (addr32 == N + 1) rd_word = dirty64[63:32];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_done_q  <= 1'b0;
         readdata_q <= '0;
      end else if (!avs_read) begin
         rd_done_q  <= 1'b0;
      end else if (!rd_done_q) begin
         rd_done_q  <= 1'b1;
         readdata_q <= rd_word;
      end
   end

   assign avs_readdata    = readdata_q;
   assign avs_waitrequest = avs_read & ~rd_done_q;

endmodule
